// File: rtl/pattern_bit_serializer_if.sv
// pattern_bit_serializer_if: word-in / bit-out handshake bundle for the serializer
interface pattern_bit_serializer_if #(parameter int WIDTH = 8);
    logic             flush;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_enable;
    logic             ser_bit;
    logic             ser_valid;
    logic             busy;
    logic             underrun;
    modport master (output flush, din, din_valid, ser_enable,
                    input  din_ready, ser_bit, ser_valid, busy, underrun);
    modport slave  (input  flush, din, din_valid, ser_enable,
                    output din_ready, ser_bit, ser_valid, busy, underrun);
endinterface

// File: rtl/pattern_bit_serializer.sv
// pattern_bit_serializer: parallel words in over valid/ready, one bit per enabled clk out
module pattern_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic                      clk,
    input logic                      rest,
    pattern_bit_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sr, hr;
    logic [CW-1:0]    cnt, idx;
    logic             hr_full, underrun_q, accept, consume, last;
    assign bus.din_ready = !rest && !bus.flush && !hr_full;
    assign accept        = bus.din_valid && bus.din_ready;
    assign consume       = (state == SHIFT) && bus.ser_enable;
    assign last          = consume && cnt == LAST;
    assign idx           = MSB_FIRST != 0 ? LAST - cnt : cnt;
    assign bus.ser_bit   = (state == SHIFT) ? sr[idx] : 1'b0;
    assign bus.ser_valid = consume;
    assign bus.busy      = state == SHIFT;
    assign bus.underrun  = underrun_q;
    always_ff @(posedge clk) begin
        if (rest || bus.flush) begin
            state      <= IDLE;
            hr_full    <= 1'b0;
            cnt        <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    sr    <= bus.din;
                    cnt   <= '0;
                    state <= SHIFT;
                end
            end else if (last) begin
                // next word joins seamlessly: queued word first, else a word arriving now
                cnt <= '0;
                if (hr_full) begin
                    sr      <= hr;
                    hr_full <= 1'b0;
                end else if (accept) begin
                    sr <= bus.din;
                end else begin
                    state      <= IDLE;
                    underrun_q <= 1'b1;
                end
            end else begin
                if (consume) cnt <= cnt + 1'b1;
                if (accept) begin
                    hr      <= bus.din;
                    hr_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pattern_bit_serializer.sv
// tb_pattern_bit_serializer: directed checks of MSB-first and LSB-first serializers
module tb_pattern_bit_serializer;
    logic clk = 1'b0;
    logic rest;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] w;
    pattern_bit_serializer_if #(.WIDTH(8)) bm ();
    pattern_bit_serializer_if #(.WIDTH(8)) bl ();
    pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (.clk(clk), .rest(rest), .bus(bm));
    pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (.clk(clk), .rest(rest), .bus(bl));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rest = 1'b1;
        bm.flush = 0; bm.din = 0; bm.din_valid = 0; bm.ser_enable = 1;
        bl.flush = 0; bl.din = 0; bl.din_valid = 0; bl.ser_enable = 0;
        // T1 reset
        tick(); tick();
        #1;
        chk("t1_ready", bm.din_ready, 0);
        chk("t1_valid", bm.ser_valid, 0);
        chk("t1_busy", bm.busy, 0);
        chk("t1_bit", bm.ser_bit, 0);
        rest = 1'b0;
        tick();
        chk("t1_ready_rel", bm.din_ready, 1);
        // T2 single word MSB first
        bm.din = 8'hD5; bm.din_valid = 1;
        tick();
        bm.din_valid = 0;
        w = 8'hD5;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_valid", bm.ser_valid, 1);
            chk($sformatf("t2_bit%0d", i), bm.ser_bit, w[7-i]);
            chk("t2_no_underrun", bm.underrun, 0);
            tick();
        end
        #1;
        chk("t2_underrun", bm.underrun, 1);
        chk("t2_busy", bm.busy, 0);
        chk("t2_valid_end", bm.ser_valid, 0);
        tick();
        chk("t2_underrun_clr", bm.underrun, 0);
        // T3 back-to-back words, holding register backpressure
        bm.din = 8'hD5; bm.din_valid = 1;
        tick();
        for (int i = 0; i < 24; i++) begin
            bm.din_valid = i <= 8;
            bm.din = (i == 0) ? 8'h35 : 8'hFF;
            w = (i < 8) ? 8'hD5 : (i < 16) ? 8'h35 : 8'hFF;
            #1;
            chk($sformatf("t3_valid%0d", i), bm.ser_valid, 1);
            chk($sformatf("t3_bit%0d", i), bm.ser_bit, w[7-(i%8)]);
            if (i <= 8) chk($sformatf("t3_ready%0d", i), bm.din_ready, (i == 0 || i == 8) ? 1 : 0);
            tick();
        end
        bm.din_valid = 0;
        #1;
        chk("t3_underrun", bm.underrun, 1);
        tick();
        // T4 ser_enable stall
        bm.din = 8'hD5; bm.din_valid = 1;
        tick();
        bm.din_valid = 0;
        w = 8'hD5;
        for (int i = 0; i < 11; i++) begin
            bm.ser_enable = !(i >= 3 && i < 6);
            #1;
            if (i >= 3 && i < 6) begin
                chk("t4_stall_valid", bm.ser_valid, 0);
                chk("t4_stall_bit", bm.ser_bit, 1);
                chk("t4_stall_busy", bm.busy, 1);
            end else begin
                chk("t4_valid", bm.ser_valid, 1);
                chk($sformatf("t4_bit%0d", i), bm.ser_bit, w[7-(i < 3 ? i : i - 3)]);
            end
            tick();
        end
        #1;
        chk("t4_underrun", bm.underrun, 1);
        tick();
        // T5 flush with HR full
        bm.din = 8'hD5; bm.din_valid = 1;
        tick();
        bm.din = 8'h35;
        tick();
        bm.din = 8'hAA; bm.flush = 1;
        #1;
        chk("t5_ready_flush", bm.din_ready, 0);
        tick();
        bm.flush = 0; bm.din_valid = 0;
        #1;
        chk("t5_busy", bm.busy, 0);
        chk("t5_valid", bm.ser_valid, 0);
        chk("t5_ready", bm.din_ready, 1);
        chk("t5_underrun", bm.underrun, 0);
        tick();
        chk("t5_busy2", bm.busy, 0);
        chk("t5_underrun2", bm.underrun, 0);
        // T6 LSB first, then reset mid-word
        bm.ser_enable = 0;
        bl.ser_enable = 1; bl.din = 8'h0B; bl.din_valid = 1;
        tick();
        bl.din_valid = 0;
        w = 8'h0B;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t6_valid", bl.ser_valid, 1);
            chk($sformatf("t6_bit%0d", i), bl.ser_bit, w[i]);
            tick();
        end
        #1;
        chk("t6_underrun", bl.underrun, 1);
        bl.din_valid = 1;
        tick();
        bl.din_valid = 0;
        #1;
        chk("t6_bit0_again", bl.ser_bit, 1);
        tick();
        rest = 1;
        tick();
        rest = 0;
        #1;
        chk("t6_rst_valid", bl.ser_valid, 0);
        chk("t6_rst_busy", bl.busy, 0);
        chk("t6_rst_underrun", bl.underrun, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
